word3_serializer: RTL

WORD3_SERIALIZER -- requirements
Module: word3_serializer

---
 rtl/word3_serializer_pkg.sv | 15 +
 rtl/word3_ser_stage.sv | 40 ++++
 rtl/word3_serializer.sv | 117 +++++++++++
 3 files changed

// File: rtl/word3_serializer_pkg.sv
// word3_serializer_pkg
//   Shared definitions for the frame serializer: controller state encoding
//   and default geometry (bits per word, words per frame).
//   Optional feature macro used by the serializer: WORD3_SERIALIZER_PARITY_EN.
package word3_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 3;

endpackage

// File: rtl/word3_ser_stage.sv
// word3_ser_stage
//   One WIDTH-bit holding register of the serializer chain. Parallel load
//   takes priority over shift; both are qualified by the clock enable.
//   Ports:
//     CLK   clock (rising edge)
//     RST   asynchronous active-low reset, clears q
//     Ce    clock enable, 0 holds q
//     ld    parallel load strobe, q <= ld_d
//     sh    shift strobe, q <= sh_d (neighbour stage or zero fill)
//     ld_d  parallel load word
//     sh_d  shift-in word
//     q     stored word
module word3_ser_stage
  import word3_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Ce,
  input  logic             ld,
  input  logic             sh,
  input  logic [WIDTH-1:0] ld_d,
  input  logic [WIDTH-1:0] sh_d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q <= '0;
    end else if (Ce) begin
      if (ld) begin
        q <= ld_d;
      end else if (sh) begin
        q <= sh_d;
      end
    end
  end

endmodule

// File: rtl/word3_serializer.sv
// word3_serializer
//   Accepts a DEPTH-word frame in parallel and emits it one word per enabled
//   cycle, word 0 first. A new frame may be accepted on the cycle that shows
//   the final word, giving gap-free back-to-back frames.
//   Optional feature: define WORD3_SERIALIZER_PARITY_EN to add the registered
//   Dpar output (XOR of Dout bits, 0 when no word is valid).
//   Ports:
//     CLK     clock (rising edge)
//     RST     asynchronous active-low reset
//     Ce      clock enable, 0 freezes all state
//     Load    frame accept request
//     Din     frame, word k = Din[k*WIDTH +: WIDTH]
//     Ready   frame can be accepted this cycle
//     Dout    current serial word (registered)
//     Dvalid  Dout holds a frame word
//     Last    Dout holds the final word of the frame
//     Dpar    (parity build only) XOR of Dout bits
module word3_serializer
  import word3_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Ce,
  input  logic                   Load,
  input  logic [DEPTH*WIDTH-1:0] Din,
  output logic                   Ready,
  output logic [WIDTH-1:0]       Dout,
  output logic                   Dvalid,
  output logic                   Last
`ifdef WORD3_SERIALIZER_PARITY_EN
  ,
  output logic                   Dpar
`endif
);

  localparam int             CW      = $clog2(DEPTH);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEPTH - 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            take;
  logic            advance;
  logic [WIDTH-1:0] chain [0:DEPTH-2];

  assign Last  = Dvalid & (cnt == CNT_MAX);
  assign Ready = (state == IDLE) | Last;

  // take/advance are not gated by Ce here; every consumer is.
  assign take    = Load & Ready;
  assign advance = (state == SHIFT) & ~take & (cnt != CNT_MAX);

  // Holding chain: chain[i] carries frame word i+1; zeros fill from the tail.
  for (genvar i = 0; i < DEPTH - 1; i++) begin : g_stage
    logic [WIDTH-1:0] sh_in;
    if (i == DEPTH - 2) begin : g_tail
      assign sh_in = '0;
    end else begin : g_mid
      assign sh_in = chain[i+1];
    end

    word3_ser_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .CLK  (CLK),
      .RST  (RST),
      .Ce   (Ce),
      .ld   (take),
      .sh   (advance),
      .ld_d (Din[(i+1)*WIDTH +: WIDTH]),
      .sh_d (sh_in),
      .q    (chain[i])
    );
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      cnt    <= '0;
      Dout   <= '0;
      Dvalid <= 1'b0;
`ifdef WORD3_SERIALIZER_PARITY_EN
      Dpar   <= 1'b0;
`endif
    end else if (Ce) begin
      if (take) begin
        // Accept also covers the Last cycle: word 0 overwrites the final word.
        state  <= SHIFT;
        cnt    <= '0;
        Dout   <= Din[WIDTH-1:0];
        Dvalid <= 1'b1;
`ifdef WORD3_SERIALIZER_PARITY_EN
        Dpar   <= ^Din[WIDTH-1:0];
`endif
      end else if (state == SHIFT) begin
        if (cnt != CNT_MAX) begin
          cnt  <= cnt + CW'(1);
          Dout <= chain[0];
`ifdef WORD3_SERIALIZER_PARITY_EN
          Dpar <= ^chain[0];
`endif
        end else begin
          state  <= IDLE;
          cnt    <= '0;
          Dout   <= '0;
          Dvalid <= 1'b0;
`ifdef WORD3_SERIALIZER_PARITY_EN
          Dpar   <= 1'b0;
`endif
        end
      end
    end
  end

endmodule
